pulse_seq_ctrl: RTL and testbench

Sequencer that drives memristor stimulus pulses on a selected channel: N repetitions of a high pulse of programmable width, separated by a programmable gap. Widths and gaps are in microseconds, derived from an internal 1 us tick. It sits between the host command decoder and the electrode switch drivers, and replaces ad-hoc chained delay stages with one counted schedule.

---
 rtl/pulse_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl.sv
// Counted stimulus sequencer: rep_num pulses of pw_us width separated by gap_us lows
// on the latched channel mask, timed from a 1 us tick divided down from clk.
module pulse_seq_ctrl #(
    parameter int unsigned CNT_1US = 50,
    parameter int unsigned CH_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CH_W-1:0] ch_sel,
    input  logic [15:0]     pw_us,
    input  logic [15:0]     gap_us,
    input  logic [7:0]      rep_num,
    output logic [CH_W-1:0] pulse_out,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [7:0]      rep_cnt
);
    localparam int unsigned US_W   = 16;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned REPC_W = REP_W + 1;
    localparam int unsigned DIV_W  = (CNT_1US > 1) ? $clog2(CNT_1US) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CH_W-1:0]   ch_q;
    logic [US_W-1:0]   pw_q;
    logic [US_W-1:0]   gap_q;
    logic [REP_W-1:0]  rep_num_q;
    logic [DIV_W-1:0]  cnt_div;
    logic [US_W-1:0]   us_cnt;

    logic              go;
    logic              tick;
    logic              pulse_end;
    logic              gap_end;
    logic              last_rep;

    logic [CH_W-1:0]   pulse_d;
    logic              busy_d;
    logic              done_d;
    logic              aborted_d;

    assign go        = (state_q == IDLE) && start;
    assign tick      = (cnt_div == DIV_W'(CNT_1US - 1));
    assign pulse_end = (state_q == PULSE) && tick && (us_cnt == pw_q - US_W'(1));
    assign gap_end   = (state_q == GAP) && tick && (us_cnt == gap_q - US_W'(1));
    assign last_rep  = ({1'b0, rep_cnt} + REPC_W'(1)) == {1'b0, rep_num_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort takes priority over every phase completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (rep_num == REP_W'(0)) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pulse_end) begin
                    state_d = last_rep ? DONE : GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_end) begin
                    state_d = PULSE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        pulse_d   = '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        aborted_d = abort && (state_q != IDLE);
        if (state_d == PULSE) begin
            pulse_d = go ? ch_sel : ch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            pulse_out <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
        end
    end

    // Config latch, completed-pulse count, and per-phase us timing (restarts on every state entry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            pw_q      <= '0;
            gap_q     <= '0;
            rep_num_q <= '0;
            rep_cnt   <= '0;
            cnt_div   <= '0;
            us_cnt    <= '0;
        end else begin
            if (go) begin
                ch_q      <= ch_sel;
                pw_q      <= (pw_us == US_W'(0)) ? US_W'(1) : pw_us;
                gap_q     <= (gap_us == US_W'(0)) ? US_W'(1) : gap_us;
                rep_num_q <= rep_num;
                rep_cnt   <= '0;
            end else if (pulse_end && !abort) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end

            if ((state_d != state_q) || (state_q == IDLE)) begin
                cnt_div <= '0;
                us_cnt  <= '0;
            end else if (tick) begin
                cnt_div <= '0;
                us_cnt  <= us_cnt + US_W'(1);
            end else begin
                cnt_div <= cnt_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: checkpoint tables per sequence plus a per-cycle
// waveform model for pulse_out, and hand-written reset/abort corner cases.
module tb_pulse_seq_ctrl;
    localparam int unsigned CNT_1US = 50;
    localparam int unsigned CH_W    = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [CH_W-1:0] ch_sel;
    logic [15:0]     pw_us;
    logic [15:0]     gap_us;
    logic [7:0]      rep_num;
    logic [CH_W-1:0] pulse_out;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [7:0]      rep_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int              k;
        logic [CH_W-1:0] pulse;
        logic            busy;
        logic            done;
        logic            aborted;
        logic [7:0]      rep;
    } vec_t;

    vec_t vecs[$];

    pulse_seq_ctrl #(.CNT_1US(CNT_1US), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ch_sel    (ch_sel),
        .pw_us     (pw_us),
        .gap_us    (gap_us),
        .rep_num   (rep_num),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .rep_cnt   (rep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        string p;
        p = $sformatf("%s k=%0d", tag, v.k);
        chk({p, " pulse_out"}, 32'(pulse_out), 32'(v.pulse));
        chk({p, " busy"},      32'(busy),      32'(v.busy));
        chk({p, " done"},      32'(done),      32'(v.done));
        chk({p, " aborted"},   32'(aborted),   32'(v.aborted));
        chk({p, " rep_cnt"},   32'(rep_cnt),   32'(v.rep));
    endtask

    function automatic void add(input int k, input logic [CH_W-1:0] p, input logic b,
                                input logic d, input logic a, input logic [7:0] r);
        vec_t v;
        v.k = k; v.pulse = p; v.busy = b; v.done = d; v.aborted = a; v.rep = r;
        vecs.push_back(v);
    endfunction

    // Ideal waveform: cycle k (1 = first cycle after the start edge), effective pw/gap in us.
    function automatic logic [CH_W-1:0] exp_pulse(input int k, input logic [CH_W-1:0] ch,
                                                  input int pw, input int gap, input int rep);
        int o;
        int per;
        o   = k - 1;
        per = (pw + gap) * int'(CNT_1US);
        if ((o / per) < rep && (o % per) < pw * int'(CNT_1US)) return ch;
        return '0;
    endfunction

    task automatic apply_start(input logic [CH_W-1:0] ch, input int pw, input int gap,
                               input int rep, input logic ab);
        @(negedge clk);
        ch_sel  = ch;
        pw_us   = 16'(pw);
        gap_us  = 16'(gap);
        rep_num = 8'(rep);
        start   = 1'b1;
        abort   = ab;
        @(posedge clk);
    endtask

    task automatic run(input string tag, input int ncyc, input int abort_at, input int start_at,
                       input bit wave, input logic [CH_W-1:0] wch, input int wpw, input int wgap,
                       input int wrep, input int exp_dones, input int exp_aborts);
        int dones;
        int aborts;
        dones  = 0;
        aborts = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (aborted === 1'b1) aborts++;
            if (wave) begin
                chk($sformatf("%s wave k=%0d", tag, k), 32'(pulse_out),
                    32'(exp_pulse(k, wch, wpw, wgap, wrep)));
            end
            foreach (vecs[i]) begin
                if (vecs[i].k == k) check_vec(vecs[i], tag);
            end
            abort = (k == abort_at);
            if (k == start_at) begin
                start   = 1'b1;
                ch_sel  = 4'b1001;
                pw_us   = 16'd1;
                gap_us  = 16'd7;
                rep_num = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " done pulses"},    32'(dones),  32'(exp_dones));
        chk({tag, " aborted pulses"}, 32'(aborts), 32'(exp_aborts));
        vecs.delete();
    endtask

    function automatic void scen1_vecs();
        add(1,   4'b0010, 1, 0, 0, 0);
        add(100, 4'b0010, 1, 0, 0, 0);
        add(101, 4'b0000, 1, 0, 0, 1);
        add(250, 4'b0000, 1, 0, 0, 1);
        add(251, 4'b0010, 1, 0, 0, 1);
        add(350, 4'b0010, 1, 0, 0, 1);
        add(351, 4'b0000, 1, 1, 0, 2);
        add(352, 4'b0000, 0, 0, 0, 2);
    endfunction

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        ch_sel  = '0;
        pw_us   = '0;
        gap_us  = '0;
        rep_num = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset pulse_out", 32'(pulse_out), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset done",      32'(done),      32'd0);
        chk("reset aborted",   32'(aborted),   32'd0);
        chk("reset rep_cnt",   32'(rep_cnt),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        // Basic sequence
        scen1_vecs();
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("basic", 355, -1, -1, 1'b1, 4'b0010, 2, 3, 2, 1, 0);

        // rep_num = 0 completes immediately
        add(1, 4'b0000, 1, 1, 0, 0);
        add(2, 4'b0000, 0, 0, 0, 0);
        apply_start(4'b1111, 5, 5, 0, 1'b0);
        run("rep0", 5, -1, -1, 1'b1, 4'b1111, 5, 5, 0, 1, 0);

        // pw_us = gap_us = 0 behave as 1 us
        add(50,  4'b0100, 1, 0, 0, 0);
        add(51,  4'b0000, 1, 0, 0, 1);
        add(250, 4'b0100, 1, 0, 0, 2);
        add(251, 4'b0000, 1, 1, 0, 3);
        add(252, 4'b0000, 0, 0, 0, 3);
        apply_start(4'b0100, 0, 0, 3, 1'b0);
        run("zero_pw_gap", 255, -1, -1, 1'b1, 4'b0100, 1, 1, 3, 1, 0);

        // Abort during GAP, then a fresh full sequence
        add(180, 4'b0000, 1, 0, 0, 1);
        add(181, 4'b0000, 0, 0, 1, 1);
        add(182, 4'b0000, 0, 0, 0, 1);
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("abort_gap", 184, 180, -1, 1'b0, 4'b0000, 1, 1, 0, 0, 1);
        scen1_vecs();
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("restart", 355, -1, -1, 1'b1, 4'b0010, 2, 3, 2, 1, 0);

        // start while busy with different config is ignored
        scen1_vecs();
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("start_busy", 355, -1, 50, 1'b1, 4'b0010, 2, 3, 2, 1, 0);

        // abort on the final PULSE->DONE edge wins over completion
        add(350, 4'b0010, 1, 0, 0, 1);
        add(351, 4'b0000, 0, 0, 1, 1);
        add(352, 4'b0000, 0, 0, 0, 1);
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("abort_last", 355, 350, -1, 1'b0, 4'b0000, 1, 1, 0, 0, 1);

        // start and abort together in IDLE: start honoured
        add(1,  4'b0001, 1, 0, 0, 0);
        add(50, 4'b0001, 1, 0, 0, 0);
        add(51, 4'b0000, 1, 1, 0, 1);
        add(52, 4'b0000, 0, 0, 0, 1);
        apply_start(4'b0001, 1, 1, 1, 1'b1);
        run("start_abort", 55, -1, -1, 1'b1, 4'b0001, 1, 1, 1, 1, 0);

        // Asynchronous reset mid-sequence
        add(119, 4'b0000, 1, 0, 0, 1);
        apply_start(4'b0010, 2, 3, 2, 1'b0);
        run("pre_reset", 119, -1, -1, 1'b0, 4'b0000, 1, 1, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst pulse_out", 32'(pulse_out), 32'd0);
        chk("async rst busy",      32'(busy),      32'd0);
        chk("async rst rep_cnt",   32'(rep_cnt),   32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("in rst done %0d", i),    32'(done),    32'd0);
            chk($sformatf("in rst aborted %0d", i), 32'(aborted), 32'd0);
            chk($sformatf("in rst busy %0d", i),    32'(busy),    32'd0);
        end
        rst_n = 1'b1;
        add(201, 4'b0000, 1, 1, 0, 2);
        add(202, 4'b0000, 0, 0, 0, 2);
        apply_start(4'b1000, 1, 2, 2, 1'b0);
        run("post_reset", 205, -1, -1, 1'b1, 4'b1000, 1, 2, 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
